// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the multiply/divide execute unit: op codes, FSM states
// and small op-decoding helpers used by the top FSM.
package ex_muldiv_pkg;

    typedef logic [2:0] md_op_t;
    typedef logic [1:0] md_state_t;

    localparam md_op_t MD_MUL    = 3'd0;
    localparam md_op_t MD_MULH   = 3'd1;
    localparam md_op_t MD_MULHSU = 3'd2;
    localparam md_op_t MD_MULHU  = 3'd3;
    localparam md_op_t MD_DIV    = 3'd4;
    localparam md_op_t MD_DIVU   = 3'd5;
    localparam md_op_t MD_REM    = 3'd6;
    localparam md_op_t MD_REMU   = 3'd7;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_MUL  = 2'd1;
    localparam md_state_t ST_DIV  = 2'd2;
    localparam md_state_t ST_DONE = 2'd3;

    function automatic logic md_is_div(input md_op_t op);
        return op[2];
    endfunction

    // DIV and REM are the signed divide ops; the U variants have op[0] set.
    function automatic logic md_is_signed_div(input md_op_t op);
        return op[2] & ~op[0];
    endfunction

    function automatic logic md_is_rem(input md_op_t op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_md_divider.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per
// cycle; sign correction is applied on the outputs while done_o is high.
module md_divider
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            done;

    assign done = busy_q && (cnt_q == CW'(XLEN));

    always_comb begin
        mag_a   = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        mag_b   = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // partial remainder while quotient bits enter at the LSB.
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;

        if (kill_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = mag_a;
            dvs_d  = mag_b;
            qneg_d = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            rneg_d = signed_i & dividend_i[XLEN-1];
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign done_o = done;
    assign quot_o = qneg_q ? -quo_q : quo_q;
    assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// RISC-V M-extension execute unit: pipelined multiplier inline, iterative
// divider in md_divider, single-issue IDLE/MUL/DIV/DONE control FSM.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] modify_data,
    output logic [4:0]      modify_address,
    output logic            busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state_q, state_d;
    md_op_t          op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            accept;
    logic            in_special;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] special_res;

    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] prod_c;
    logic [2*XLEN-1:0] prod_tap;
    logic [XLEN-1:0]   mul_res;

    assign accept     = in_valid && (state_q == ST_IDLE) && !flush;
    assign in_special = md_is_div(op) &&
                        ((op2 == '0) ||
                         (md_is_signed_div(op) && (op1 == MOST_NEG) && (op2 == '1)));
    assign div_start  = accept && md_is_div(op) && !in_special;

    md_divider #(
        .XLEN(XLEN)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .kill_i    (flush),
        .start_i   (div_start),
        .signed_i  (md_is_signed_div(op)),
        .dividend_i(op1),
        .divisor_i (op2),
        .done_o    (div_done),
        .quot_o    (div_quot),
        .rem_o     (div_rem)
    );

    // Full 2*XLEN product of sign- or zero-extended operands; the low 2*XLEN
    // bits are exact for every signedness combination.
    assign mul_a_signed = (op_q == MD_MULH) || (op_q == MD_MULHSU);
    assign mul_b_signed = (op_q == MD_MULH);
    assign mul_a_ext    = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
    assign mul_b_ext    = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
    assign prod_c       = mul_a_ext * mul_b_ext;

    if (MUL_CYCLES == 1) begin : g_no_pipe
        assign prod_tap = prod_c;
    end else begin : g_pipe
        localparam int unsigned STAGES = MUL_CYCLES - 1;
        logic [2*XLEN-1:0] pipe_q [STAGES];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 0; i < STAGES; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= prod_c;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign prod_tap = pipe_q[STAGES-1];
    end

    assign mul_res = (op_q == MD_MUL) ? prod_tap[XLEN-1:0] : prod_tap[2*XLEN-1:XLEN];

    // A zero divisor takes precedence; otherwise the special case is overflow.
    always_comb begin
        if (b_q == '0) begin
            special_res = md_is_rem(op_q) ? a_q : '1;
        end else begin
            special_res = md_is_rem(op_q) ? '0 : a_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        res_d     = res_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d   = md_is_div(op) ? ST_DIV : ST_MUL;
                        op_d      = op;
                        a_d       = op1;
                        b_d       = op2;
                        rd_d      = rd_in;
                        cnt_d     = '0;
                        special_d = in_special;
                    end
                end
                ST_MUL: begin
                    if (cnt_q == 3'(MUL_CYCLES - 1)) begin
                        state_d = ST_DONE;
                        res_d   = mul_res;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_DIV: begin
                    if (special_q) begin
                        state_d = ST_DONE;
                        res_d   = special_res;
                    end else if (div_done) begin
                        state_d = ST_DONE;
                        res_d   = md_is_rem(op_q) ? div_rem : div_quot;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MUL;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            special_q <= special_d;
            res_q     <= res_d;
        end
    end

    assign in_ready       = (state_q == ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign modify_data    = res_q;
    assign modify_address = rd_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL take parameter XLEN, default 32, the operand/result width; legal values are 32 and 64.
REQ-002 SHALL take parameter MUL_CYCLES, default 2, the multiply latency in cycles; legal range is 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous kill of any in-flight or held operation.
REQ-006 SHALL have port in_valid, input, 1 bit: the issue request.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit can accept an operation.
REQ-008 SHALL have port op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have ports op1 and op2, input, XLEN bits each: rs1 and rs2 values.
REQ-010 SHALL have port rd_in, input, 5 bits: the destination register.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-013 SHALL have port modify_data, output, XLEN bits: the result.
REQ-014 SHALL have port modify_address, output, 5 bits: the destination register.
REQ-015 SHALL have port busy, output, 1 bit: the unit is not IDLE; it drives the pipeline stall.

Function
REQ-016 SHALL implement the states IDLE, MUL, DIV and DONE, with a registered state.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 SHALL accept an operation on a rising edge where in_valid=1, in_ready=1 and flush=0, latching op, op1, op2 and rd_in.
REQ-019 SHALL, after acceptance, go to MUL for op 0-3 and to DIV for op 4-7.
REQ-020 SHALL, in MUL, count MUL_CYCLES-1 further edges, then enter DONE; out_valid is therefore high exactly MUL_CYCLES cycles after the accept edge.
REQ-021 SHALL form the 2*XLEN product:
- MUL returns the low XLEN bits.
- MULH returns the high bits of signed x signed.
- MULHSU returns the high bits of signed op1 x unsigned op2.
- MULHU returns the high bits of unsigned x unsigned.
REQ-022 SHALL, in DIV, run a restoring divide on operand magnitudes at one quotient bit per cycle for XLEN cycles, then apply sign correction in one cycle and enter DONE; latency is XLEN+1 cycles.
REQ-023 SHALL give the quotient sign as op1 sign XOR op2 sign, and the remainder sign as the op1 sign (signed ops only).
REQ-024 SHALL treat divide-by-zero (op2=0) as a special case:
- enter DONE on the edge after accept (latency 1);
- quotient is all ones;
- remainder is op1.
REQ-025 SHALL treat signed overflow (DIV/REM with op1=most-negative and op2=-1) as a special case:
- latency 1;
- quotient is op1;
- remainder is 0.
REQ-026 SHALL, in DONE, hold out_valid=1 and keep modify_data and modify_address stable until an edge with out_ready=1, then return to IDLE.
REQ-027 SHALL NOT accept a new operation in the same cycle as DONE retires; there is no back-to-back issue.
REQ-028 SHALL, when flush=1 on any edge, enter IDLE and discard the result; out_valid=0 from the next cycle; flush has priority over accept and retire in the same cycle.
REQ-029 SHALL set busy=1 in MUL, DIV and DONE.

Reset
REQ-030 SHALL, on rst low, immediately drive the following:
- state=IDLE;
- out_valid=0, busy=0 and in_ready=1;
- modify_data=0 and modify_address=0;
- internal counter and operand registers cleared.
REQ-031 SHALL abandon a mid-divide operation at reset with no residual output after rst rises.
REQ-032 SHALL act on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL place the op encodings (MD_MUL..MD_REMU) and state encodings in the shared defines file, beside the existing EX_* macros.
REQ-034 SHALL place the iterative divider datapath (remainder/quotient shift registers, bit counter) in sub-module md_divider, with start/done handshaking to the FSM.
REQ-035 SHALL keep the multiplier inline as a registered product, with MUL_CYCLES-1 retiming stages.

Verification
REQ-036 SHALL cover: MULH op1=0x80000000, op2=0x80000000 -> out_valid at cycle 2, modify_data=0x40000000.
REQ-037 SHALL cover: DIV op1=-7, op2=2 -> out_valid at cycle 33, result 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
REQ-038 SHALL cover: DIVU op1=5, op2=0 -> out_valid at cycle 1, result 0xFFFFFFFF; REMU -> 5.
REQ-039 SHALL cover: DIV op1=0x80000000, op2=0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
REQ-040 SHALL cover: out_ready held low for 5 cycles in DONE -> data stable and in_ready=0 throughout; retire on the sixth cycle; in_ready=1 the cycle after.
REQ-041 SHALL cover: flush at cycle 10 of a DIV, then rst pulsed low mid-MUL -> both return to IDLE with no out_valid pulse; a following MUL 3x4 returns 12.
